// File: rtl/phrase_sequencer.sv
// Phrase sequencer: queues clip IDs, then plays them back-to-back through an
// external audio controller with a fixed silence gap between clips.
module phrase_sequencer #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 360000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [4:0]               push_id,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     play,
    input  logic                     abort,
    output logic                     busy,
    output logic [4:0]               clip_id,
    input  logic [23:0]              clip_start,
    input  logic [23:0]              clip_end,
    output logic [23:0]              start_address,
    output logic [23:0]              end_address,
    output logic                     audio_start,
    input  logic                     audio_finish,
    output logic                     done
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam bit HAS_GAP = (GAP_CYCLES != 0);
    localparam logic [31:0] GAP_LOAD = HAS_GAP ? 32'(GAP_CYCLES - 1) : 32'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_PLAY,
        S_GAP
    } state_t;

    state_t state, next_state;

    logic [4:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   gap_cnt;

    logic pop, push_ok, has_next, gap_done, finish_run;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    // An abort on the decision edge flushes the queue, so it must not count as a next clip.
    assign has_next = !empty && !abort;
    assign gap_done = (gap_cnt == 32'd0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        finish_run = 1'b0;
        case (state)
            S_IDLE: begin
                if (play) begin
                    if (has_next) begin
                        next_state = S_FETCH;
                    end else begin
                        finish_run = 1'b1;
                    end
                end
            end
            S_FETCH: next_state = S_LOAD;
            S_LOAD:  next_state = S_START;
            S_START: begin
                if (!audio_finish) begin
                    next_state = S_PLAY;
                end
            end
            S_PLAY: begin
                if (audio_finish) begin
                    if (HAS_GAP) begin
                        next_state = S_GAP;
                    end else if (has_next) begin
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_IDLE;
                        finish_run = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_done) begin
                    if (has_next) begin
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_IDLE;
                        finish_run = 1'b1;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy    = (state != S_IDLE);
        pop     = (state == S_FETCH) && !empty;
        // A full queue still accepts a push on the same edge as a pop.
        push_ok = push && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (push_ok && !abort) begin
            mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt <= 32'd0;
        end else if (state == S_PLAY && audio_finish) begin
            gap_cnt <= GAP_LOAD;
        end else if (state == S_GAP && !gap_done) begin
            gap_cnt <= gap_cnt - 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clip_id       <= 5'd0;
            start_address <= 24'd0;
            end_address   <= 24'd0;
            audio_start   <= 1'b0;
            done          <= 1'b0;
        end else begin
            if (state == S_FETCH) begin
                clip_id <= mem[rd_ptr];
            end
            if (state == S_LOAD) begin
                start_address <= clip_start;
                end_address   <= clip_end;
            end
            audio_start <= (next_state == S_START);
            done        <= finish_run;
        end
    end

endmodule

// File: tb/tb_phrase_sequencer.sv
// Bench for phrase_sequencer: queue vector table, directed playback scenarios,
// and randomized queue traffic checked against a queue-based reference model.
module tb_phrase_sequencer;
    localparam int DEPTH = 8;
    localparam int GAP   = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset, push, play, abort, audio_finish;
    logic [4:0]    push_id, clip_id;
    logic          full, empty, busy, audio_start, done;
    logic [CW-1:0] count;
    logic [23:0]   clip_start, clip_end, start_address, end_address;

    phrase_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .push(push), .push_id(push_id),
        .full(full), .empty(empty), .count(count), .play(play), .abort(abort),
        .busy(busy), .clip_id(clip_id), .clip_start(clip_start), .clip_end(clip_end),
        .start_address(start_address), .end_address(end_address),
        .audio_start(audio_start), .audio_finish(audio_finish), .done(done)
    );

    always #10 clk = ~clk;

    assign clip_start = 24'(clip_id) * 24'd1000;
    assign clip_end   = 24'(clip_id) * 24'd1000 + 24'd99;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Audio controller model and output monitor, evaluated on falling edges.
    int done_cycles, cyc, fin_rise_cyc, ack_cnt, fin_cnt;
    bit prev_start;
    int log_start[$], log_end[$], gaps[$];

    initial begin
        audio_finish = 1'b1;
        done_cycles = 0; cyc = 0; fin_rise_cyc = -1; ack_cnt = 0; fin_cnt = 0; prev_start = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ack_cnt = 0; fin_cnt = 0; audio_finish = 1'b1; prev_start = 0;
            end else begin
                if (ack_cnt > 0) begin
                    ack_cnt--;
                    if (ack_cnt == 0) begin audio_finish = 1'b0; fin_cnt = 20; end
                end else if (fin_cnt > 0) begin
                    fin_cnt--;
                    if (fin_cnt == 0) begin audio_finish = 1'b1; fin_rise_cyc = cyc; end
                end
                if (done) done_cycles++;
                if (audio_start && !prev_start) begin
                    log_start.push_back(int'(start_address));
                    log_end.push_back(int'(end_address));
                    if (fin_rise_cyc >= 0) gaps.push_back(cyc - fin_rise_cyc);
                    ack_cnt = 2;
                end
                prev_start = audio_start;
                cyc++;
            end
        end
    end

    task automatic idle_cycle(input bit p, input bit [4:0] id, input bit ab);
        @(negedge clk);
        push = p; push_id = id; abort = ab;
        @(posedge clk);
        #1;
        push = 1'b0; abort = 1'b0;
    endtask

    task automatic play_pulse();
        @(negedge clk);
        play = 1'b1;
        @(posedge clk);
        #1;
        play = 1'b0;
    endtask

    task automatic start_run();
        done_cycles = 0;
        fin_rise_cyc = -1;
        log_start.delete();
        log_end.delete();
        gaps.delete();
    endtask

    task automatic wait_done(input string name, input int bound);
        int n;
        n = 0;
        while (done_cycles == 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, int'(done_cycles > 0), 1);
        repeat (10) @(negedge clk);
        check({name, "_done_pulses"}, done_cycles, 1);
    endtask

    task automatic wait_starts(input string name, input int n, input int bound);
        int k;
        k = 0;
        while (log_start.size() < n && k < bound) begin
            @(negedge clk);
            k++;
        end
        check({name, "_start_seen"}, int'(log_start.size() >= n), 1);
    endtask

    task automatic check_clips(input string name, input int ids[$]);
        check({name, "_clip_count"}, log_start.size(), ids.size());
        for (int i = 0; i < ids.size() && i < log_start.size(); i++) begin
            check($sformatf("%s_start%0d", name, i), log_start[i], ids[i] * 1000);
            check($sformatf("%s_end%0d", name, i), log_end[i], ids[i] * 1000 + 99);
        end
    endtask

    typedef struct {
        bit       push;
        bit [4:0] id;
        bit       abort;
        int       exp_count;
        bit       exp_full;
        bit       exp_empty;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int mq[$];
        int exp_ids[$];
        int n;
        bit p, ab;
        bit [4:0] rid;

        reset = 1'b1; push = 1'b0; push_id = 5'd0; play = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_clip_id", int'(clip_id), 0);
        check("rst_start_addr", int'(start_address), 0);
        check("rst_end_addr", int'(end_address), 0);
        check("rst_audio_start", int'(audio_start), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b0;

        // Queue behaviour while idle
        vecs.push_back('{1'b1, 5'd3, 1'b0, 1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 5'd7, 1'b0, 2, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 5'd0, 1'b0, 2, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 5'd0, 1'b1, 0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 5'd4, 1'b1, 0, 1'b0, 1'b1});
        for (int i = 0; i < DEPTH; i++)
            vecs.push_back('{1'b1, 5'(10 + i), 1'b0, i + 1, (i == DEPTH - 1), 1'b0});
        vecs.push_back('{1'b1, 5'd18, 1'b0, DEPTH, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 5'd0, 1'b1, 0, 1'b0, 1'b1});
        for (int i = 0; i < vecs.size(); i++) begin
            idle_cycle(vecs[i].push, vecs[i].id, vecs[i].abort);
            check($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
            check($sformatf("vec%0d_full", i), int'(full), int'(vecs[i].exp_full));
            check($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].exp_empty));
        end

        // Play on an empty queue: immediate single done, never busy
        start_run();
        play_pulse();
        check("empty_play_done", int'(done), 1);
        check("empty_play_busy", int'(busy), 0);
        @(posedge clk); #1;
        check("empty_play_done_clear", int'(done), 0);
        check("empty_play_busy_after", int'(busy), 0);

        // Three clips with gaps
        idle_cycle(1'b1, 5'd3, 1'b0);
        idle_cycle(1'b1, 5'd7, 1'b0);
        idle_cycle(1'b1, 5'd1, 1'b0);
        start_run();
        play_pulse();
        check("three_busy", int'(busy), 1);
        wait_done("three", 400);
        exp_ids = '{3, 7, 1};
        check_clips("three", exp_ids);
        check("three_gap_count", gaps.size(), 2);
        foreach (gaps[i]) check($sformatf("three_gap%0d", i), gaps[i], GAP + 3);
        check("three_busy_end", int'(busy), 0);

        // Overfill: ninth push dropped
        for (int i = 0; i < 9; i++) idle_cycle(1'b1, 5'(10 + i), 1'b0);
        check("overfill_count", int'(count), DEPTH);
        check("overfill_full", int'(full), 1);
        start_run();
        play_pulse();
        wait_done("overfill", 600);
        exp_ids = '{10, 11, 12, 13, 14, 15, 16, 17};
        check_clips("overfill", exp_ids);

        // Push on the FETCH pop edge of a full queue
        for (int i = 0; i < DEPTH; i++) idle_cycle(1'b1, 5'(20 + i), 1'b0);
        start_run();
        @(negedge clk); play = 1'b1;
        @(negedge clk); play = 1'b0; push = 1'b1; push_id = 5'd30;
        @(posedge clk); #1; push = 1'b0;
        check("pop_push_count", int'(count), DEPTH);
        wait_done("pop_push", 700);
        exp_ids = '{20, 21, 22, 23, 24, 25, 26, 27, 30};
        check_clips("pop_push", exp_ids);

        // Abort while the second clip plays
        for (int i = 1; i <= 5; i++) idle_cycle(1'b1, 5'(i), 1'b0);
        start_run();
        play_pulse();
        wait_starts("abort", 2, 300);
        repeat (5) @(negedge clk);
        idle_cycle(1'b0, 5'd0, 1'b1);
        check("abort_count", int'(count), 0);
        check("abort_empty", int'(empty), 1);
        repeat (2) @(negedge clk);
        check("abort_clip_continues", int'(busy), 1);
        wait_done("abort", 300);
        repeat (40) @(negedge clk);
        exp_ids = '{1, 2};
        check_clips("abort", exp_ids);

        // Randomized queue traffic against a queue model, then play it out
        for (int it = 0; it < 6; it++) begin
            mq.delete();
            idle_cycle(1'b0, 5'd0, 1'b1);
            n = $urandom_range(30, 10);
            for (int c = 0; c < n; c++) begin
                p   = ($urandom_range(3, 0) != 0);
                rid = 5'($urandom_range(31, 0));
                ab  = ($urandom_range(15, 0) == 0);
                idle_cycle(p, rid, ab);
                if (ab) mq.delete();
                else if (p && mq.size() < DEPTH) mq.push_back(int'(rid));
                check("rand_count", int'(count), mq.size());
                check("rand_full", int'(full), int'(mq.size() == DEPTH));
                check("rand_empty", int'(empty), int'(mq.size() == 0));
            end
            start_run();
            play_pulse();
            wait_done("rand", 40 * (mq.size() + 1) + 100);
            check_clips("rand", mq);
        end

        // Reset during START, then normal operation
        idle_cycle(1'b1, 5'd6, 1'b0);
        start_run();
        play_pulse();
        wait_starts("rst_mid", 1, 50);
        reset = 1'b1;
        #1;
        check("rst_mid_audio_start", int'(audio_start), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_empty", int'(empty), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_cycle(1'b1, 5'd9, 1'b0);
        check("rst_mid_push_count", int'(count), 1);
        start_run();
        play_pulse();
        wait_done("rst_mid", 200);
        exp_ids = '{9};
        check_clips("rst_mid", exp_ids);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
